// File: rtl/instr_seq_pkg.sv
// ============================================================================
//  Module      : instr_seq_pkg
//  Description : Shared opcode classes, sequencer state encoding and default
//                widths for the TIS-100 node instruction sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package instr_seq_pkg;

   // Default widths of the sequencer datapath
   localparam int DEF_MAX_ENTRIES = 16;
   localparam int DEF_OP_W        = 21;
   localparam int DEF_ACC_W       = 11;
   localparam int DEF_OFF_W       = 11;

   // Opcode classes presented by the decode stage
   localparam logic [3:0] OP_NOP = 4'd0;
   localparam logic [3:0] OP_MOV = 4'd1;
   localparam logic [3:0] OP_SWP = 4'd2;
   localparam logic [3:0] OP_SAV = 4'd3;
   localparam logic [3:0] OP_ADD = 4'd4;
   localparam logic [3:0] OP_SUB = 4'd5;
   localparam logic [3:0] OP_NEG = 4'd6;
   localparam logic [3:0] OP_JMP = 4'd7;
   localparam logic [3:0] OP_JEZ = 4'd8;
   localparam logic [3:0] OP_JNZ = 4'd9;
   localparam logic [3:0] OP_JGZ = 4'd10;
   localparam logic [3:0] OP_JLZ = 4'd11;
   localparam logic [3:0] OP_JRO = 4'd12;

   // Load/run state machine encoding
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_RUN  = 2'd2
   } state_t;

endpackage

`default_nettype wire

// File: rtl/instr_seq_prog_ram.sv
// ============================================================================
//  Module      : instr_seq_prog_ram
//  Description : Program store, one synchronous write port and one
//                asynchronous read port (distributed RAM style).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_seq_prog_ram #(
   parameter int DEPTH = 16,
   parameter int AW    = 4,
   parameter int DW    = 21
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);

   logic [DW-1:0] r_mem [DEPTH];

   // Write port; contents are deliberately left unreset
   always_ff @(posedge clk) begin
      if (we) r_mem[waddr] <= wdata;
   end

   assign rdata = r_mem[raddr];

endmodule

`default_nettype wire

// File: rtl/instr_seq.sv
// ============================================================================
//  Module      : instr_seq
//  Description : Loadable instruction sequencer for a TIS-100 node. Holds the
//                load/run FSM, program length, program counter with clamped
//                relative jumps, and the sticky load error flag.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_seq
   import instr_seq_pkg::*;
#(
   parameter int MAX_ENTRIES = DEF_MAX_ENTRIES,
   parameter int OP_W        = DEF_OP_W,
   parameter int ACC_W       = DEF_ACC_W,
   parameter int OFF_W       = DEF_OFF_W,
   localparam int PC_W       = $clog2(MAX_ENTRIES)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clk_en,
   input  logic [3:0]       op,
   input  logic [ACC_W-1:0] acc,
   input  logic [OFF_W-1:0] jmp_off,
   input  logic             load_en,
   input  logic [PC_W-1:0]  load_addr,
   input  logic             load_last,
   input  logic [OP_W-1:0]  load_data,
   output logic [OP_W-1:0]  opcode,
   output logic [PC_W-1:0]  pc,
   output logic             running,
   output logic             load_err
);

   // Program length must hold MAX_ENTRIES itself; jump target is one bit
   // wider than the offset so pc + offset never overflows (needs T_W > LEN_W).
   localparam int LEN_W = PC_W + 1;
   localparam int T_W   = OFF_W + 1;
   localparam logic [LEN_W-1:0] C_MAX_LEN = LEN_W'(MAX_ENTRIES);

   state_t            r_state, w_state_nx;
   logic [PC_W-1:0]   r_pc, w_pc_nx;
   logic [LEN_W-1:0]  r_prog_len, w_prog_len_nx;
   logic              r_load_err, w_load_err_nx;
   logic              r_running;

   logic              w_addr_ok;
   logic              w_wr_en;
   logic [OP_W-1:0]   w_rd_data;
   logic              w_taken;
   logic [T_W-1:0]    w_target;
   logic              w_t_neg;
   logic              w_t_high;
   logic [LEN_W-1:0]  w_len_m1;
   logic [PC_W-1:0]   w_pc_seq;
   logic [PC_W-1:0]   w_pc_jump;

   assign w_addr_ok = ({1'b0, load_addr} < C_MAX_LEN);
   assign w_wr_en   = load_en & w_addr_ok;

   instr_seq_prog_ram #(
      .DEPTH (MAX_ENTRIES),
      .AW    (PC_W),
      .DW    (OP_W)
   ) u_prog_ram (
      .clk   (clk),
      .we    (w_wr_en),
      .waddr (load_addr),
      .wdata (load_data),
      .raddr (r_pc),
      .rdata (w_rd_data)
   );

   // Jump condition from opcode class and signed accumulator
   always_comb begin
      w_taken = 1'b0;
      case (op)
         OP_JMP, OP_JRO: w_taken = 1'b1;
         OP_JEZ:         w_taken = (acc == '0);
         OP_JNZ:         w_taken = (acc != '0);
         OP_JGZ:         w_taken = !acc[ACC_W-1] && (acc != '0);
         OP_JLZ:         w_taken = acc[ACC_W-1];
         default:        w_taken = 1'b0;
      endcase
   end

   // Target = zero-extended pc + sign-extended offset, clamped to [0, len-1]
   assign w_target  = {{(T_W-PC_W){1'b0}}, r_pc} + {jmp_off[OFF_W-1], jmp_off};
   assign w_t_neg   = w_target[T_W-1];
   assign w_t_high  = (w_target >= {{(T_W-LEN_W){1'b0}}, r_prog_len});
   assign w_len_m1  = r_prog_len - LEN_W'(1);
   assign w_pc_seq  = ({1'b0, r_pc} == w_len_m1) ? '0 : r_pc + PC_W'(1);
   assign w_pc_jump = w_t_neg  ? '0 :
                      w_t_high ? w_len_m1[PC_W-1:0] : w_target[PC_W-1:0];

   // Next-state logic: loads take priority over execution steps
   always_comb begin
      w_state_nx    = r_state;
      w_pc_nx       = r_pc;
      w_prog_len_nx = r_prog_len;
      w_load_err_nx = r_load_err;
      if (load_en) begin
         w_pc_nx = '0;
         if (!w_addr_ok) w_load_err_nx = 1'b1;
         if (load_last) begin
            if (w_addr_ok) begin
               w_state_nx    = ST_RUN;
               w_prog_len_nx = {1'b0, load_addr} + LEN_W'(1);
            end else begin
               w_state_nx = ST_IDLE;
            end
         end else begin
            w_state_nx = ST_LOAD;
         end
      end else if ((r_state == ST_RUN) && clk_en) begin
         w_pc_nx = w_taken ? w_pc_jump : w_pc_seq;
      end
   end

   // State, pc, length and flag registers
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= ST_IDLE;
         r_pc       <= '0;
         r_prog_len <= '0;
         r_load_err <= 1'b0;
         r_running  <= 1'b0;
      end else begin
         r_state    <= w_state_nx;
         r_pc       <= w_pc_nx;
         r_prog_len <= w_prog_len_nx;
         r_load_err <= w_load_err_nx;
         r_running  <= (w_state_nx == ST_RUN);
      end
   end

   assign opcode   = (r_state == ST_RUN) ? w_rd_data : '0;
   assign pc       = r_pc;
   assign running  = r_running;
   assign load_err = r_load_err;

endmodule

`default_nettype wire

// File: tb/tb_instr_seq.sv
// ============================================================================
//  Module      : tb_instr_seq
//  Description : Directed self-checking bench for instr_seq. Uses a
//                12-entry program store so that out-of-range load addresses
//                are representable on the 4-bit address port.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instr_seq;
   import instr_seq_pkg::*;

   localparam int MAXE = 12;
   localparam int OPW  = 21;
   localparam int ACCW = 11;
   localparam int OFFW = 11;
   localparam int PCW  = 4;

   logic            clk = 1'b0;
   logic            reset;
   logic            clk_en;
   logic [3:0]      op;
   logic [ACCW-1:0] acc;
   logic [OFFW-1:0] jmp_off;
   logic            load_en;
   logic [PCW-1:0]  load_addr;
   logic            load_last;
   logic [OPW-1:0]  load_data;
   logic [OPW-1:0]  opcode;
   logic [PCW-1:0]  pc;
   logic            running;
   logic            load_err;

   int checks   = 0;
   int failures = 0;

   instr_seq #(
      .MAX_ENTRIES (MAXE),
      .OP_W        (OPW),
      .ACC_W       (ACCW),
      .OFF_W       (OFFW)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .clk_en    (clk_en),
      .op        (op),
      .acc       (acc),
      .jmp_off   (jmp_off),
      .load_en   (load_en),
      .load_addr (load_addr),
      .load_last (load_last),
      .load_data (load_data),
      .opcode    (opcode),
      .pc        (pc),
      .running   (running),
      .load_err  (load_err)
   );

   always #5 clk = ~clk;

   function automatic logic [OPW-1:0] dw(input int a);
      return 21'h0A5000 + 21'(a) * 21'h000111;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
         $error("check %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input int a, input logic last);
      load_en   = 1'b1;
      load_addr = PCW'(a);
      load_last = last;
      load_data = dw(a);
      tick();
      load_en   = 1'b0;
      load_last = 1'b0;
   endtask

   task automatic step(input logic [3:0] o, input int a, input int off);
      op      = o;
      acc     = ACCW'(a);
      jmp_off = OFFW'(off);
      clk_en  = 1'b1;
      tick();
      clk_en  = 1'b0;
   endtask

   task automatic check_run(input string tag, input int exp_pc);
      check({tag, ".pc"}, 32'(pc), 32'(exp_pc));
      check({tag, ".op"}, 32'(opcode), 32'(dw(exp_pc)));
   endtask

   initial begin
      int seq_exp [6] = '{1, 2, 3, 0, 1, 2};
      reset = 1'b1; clk_en = 1'b0; op = OP_NOP; acc = '0; jmp_off = '0;
      load_en = 1'b0; load_addr = '0; load_last = 1'b0; load_data = '0;
      tick(); tick();
      check("rst.pc", 32'(pc), 32'd0);
      check("rst.running", 32'(running), 32'd0);
      check("rst.opcode", 32'(opcode), 32'd0);
      check("rst.load_err", 32'(load_err), 32'd0);
      reset = 1'b0;
      tick();

      // Four-word program, sequential stepping with wrap
      load(0, 1'b0);
      check("ld.running", 32'(running), 32'd0);
      check("ld.opcode", 32'(opcode), 32'd0);
      load(1, 1'b0);
      load(2, 1'b0);
      load(3, 1'b1);
      check("ld4.running", 32'(running), 32'd1);
      check_run("ld4.start", 0);
      for (int i = 0; i < 6; i++) step(OP_NOP, 0, 0);
      check_run("seq6", seq_exp[5]);

      // Ten-word program, clamped jumps
      for (int i = 0; i < 9; i++) load(i, 1'b0);
      load(9, 1'b1);
      check_run("ld10.start", 0);
      step(OP_NOP, 0, 0);
      step(OP_NOP, 0, 0);
      check_run("len10.pc2", 2);
      step(OP_JMP, 0, -5);
      check_run("jmp.neg_clamp", 0);
      step(OP_NOP, 0, 0);
      step(OP_NOP, 0, 0);
      step(OP_JMP, 0, 20);
      check_run("jmp.high_clamp", 9);
      step(OP_NOP, 0, 0);
      check_run("wrap.len10", 0);

      // Conditional jumps
      for (int i = 0; i < 4; i++) step(OP_NOP, 0, 0);
      check_run("cond.pc4", 4);
      step(OP_JGZ, -3, 3);
      check_run("jgz.not_taken", 5);
      step(OP_JMP, 0, -1);
      check_run("jmp.back1", 4);
      step(OP_JLZ, -3, -2);
      check_run("jlz.taken", 2);
      step(OP_JEZ, 0, 5);
      check_run("jez.taken", 7);
      step(OP_JNZ, 0, 1);
      check_run("jnz.not_taken", 8);
      tick();
      check_run("hold.no_clk_en", 8);
      step(OP_JRO, 0, -8);
      check_run("jro.taken", 0);
      step(OP_JNZ, 1, 3);
      check_run("jnz.taken", 3);
      step(OP_JGZ, 5, 2);
      check_run("jgz.taken", 5);

      // Load during RUN wins over clk_en and aborts execution
      op = OP_NOP; clk_en = 1'b1;
      load(0, 1'b0);
      clk_en = 1'b0;
      check("abort.pc", 32'(pc), 32'd0);
      check("abort.running", 32'(running), 32'd0);
      check("abort.opcode", 32'(opcode), 32'd0);
      step(OP_JMP, 0, 3);
      check("load.clk_en_ignored", 32'(pc), 32'd0);

      // Out-of-range load address with load_last
      load(14, 1'b1);
      check("badaddr.load_err", 32'(load_err), 32'd1);
      check("badaddr.running", 32'(running), 32'd0);
      check("badaddr.opcode", 32'(opcode), 32'd0);
      load(0, 1'b1);
      check("len1.running", 32'(running), 32'd1);
      check("len1.load_err_sticky", 32'(load_err), 32'd1);
      check_run("len1.start", 0);
      step(OP_NOP, 0, 0);
      check_run("len1.hold", 0);
      step(OP_JMP, 0, 5);
      check_run("len1.jmp_clamp", 0);

      // Reset mid-RUN
      load(9, 1'b1);
      check_run("reload.start", 0);
      step(OP_JMP, 0, 7);
      check_run("reload.pc7", 7);
      reset = 1'b1; clk_en = 1'b1; op = OP_NOP;
      tick();
      check("rst_run.pc", 32'(pc), 32'd0);
      check("rst_run.running", 32'(running), 32'd0);
      check("rst_run.opcode", 32'(opcode), 32'd0);
      check("rst_run.load_err", 32'(load_err), 32'd0);
      reset = 1'b0;
      tick(); tick();
      clk_en = 1'b0;
      check("idle.pc", 32'(pc), 32'd0);
      check("idle.running", 32'(running), 32'd0);
      check("idle.opcode", 32'(opcode), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
